imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time program loader that sits directly upstream of the mini RV32I core. It receives a framed byte stream over a valid/ready interface and assembles little-endian 32-bit words. Each word is written into the core's instruction memory through a single-word write port. The core is held in reset until a complete, well-formed frame has been committed, then released.

## Interface
Parameters:
- IMEM_WORDS, 64, instruction memory depth in words; maximum accepted frame length.
- ADDR_W, 6, word-address width; must satisfy 2**ADDR_W >= IMEM_WORDS.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- restart  in  1  one-cycle request to abort or finish and reload; re-enters IDLE.
- in_valid  in  1  byte-stream valid.
- in_data  in  8  byte-stream data.
- in_ready  out  1  byte-stream ready; a byte is accepted on an edge where in_valid && in_ready.
- imem_we  out  1  instruction-memory write enable, one-cycle pulse per word.
- imem_addr  out  ADDR_W  word address of the write.
- imem_wdata  out  32  word to write.
- core_rst  out  1  reset to the core; high until load completes.
- done  out  1  frame committed, core running.
- err  out  1  frame rejected, core held in reset.
- word_count  out  ADDR_W+1  words written in the current frame.

## Operation
- Frame format: header 0xA5, length byte N (words), then 4N payload bytes, least-significant byte first per word. With LOADER_CHECKSUM_EN, one trailing checksum byte follows.
- States and transitions:
  - IDLE: non-0xA5 bytes are dropped; 0xA5 -> LEN.
  - LEN: N==0 or N>IMEM_WORDS -> ERR; otherwise latch N -> DATA.
  - DATA: shift bytes into the word assembler with a 2-bit byte counter.
    - On the 4th byte, register imem_we=1, imem_addr=word_count, imem_wdata=assembled word, then increment word_count.
    - After word N: -> CHK if the macro is defined, else -> DONE.
  - CHK: see Configuration.
  - DONE: core_rst=0, done=1, in_ready=0.
  - ERR: core_rst=1, err=1, in_ready=0.
- in_ready = 1 in IDLE/LEN/DATA/CHK. It is 0 in DONE/ERR and while reset is high.
- restart (any state) -> IDLE on the next edge:
  - core_rst=1; done, err, word_count, byte counter and checksum cleared.
  - Words already written stay in imem.
  - restart has priority over a byte accepted in the same cycle; that byte is discarded.
- reset mid-frame: identical to restart, plus all outputs return to their reset values.
- Reset values: imem_we 0, imem_addr 0, imem_wdata 0, core_rst 1, done 0, err 0, word_count 0, state IDLE.
- The address never wraps: word_count <= N <= IMEM_WORDS is guaranteed by the LEN check.

## Timing
- Bytes can be accepted back-to-back, one per cycle; there is no stall inside a frame.
- Word write: 4th byte accepted at edge k -> imem_we high for exactly the cycle between edges k and k+1 -> memory commits at edge k+1.
- Release, without the macro: last payload byte at edge k -> state DONE at k -> core_rst falls and done rises at edge k+1. The core therefore never fetches before the final write has committed.
- Release, with the macro: checksum byte accepted at edge j -> core_rst/done (or err) change at edge j+1.
- Header-to-release latency for N words: 2 + 4N (+1 with checksum) accepted bytes, plus 1 cycle.

## Configuration
- LOADER_CHECKSUM_EN defined:
  - A running XOR of all 4N payload bytes is kept.
  - In CHK the next byte is compared with it: equal -> DONE; different -> ERR.
  - In the ERR case imem is already written but core_rst stays 1.
- LOADER_CHECKSUM_EN undefined:
  - No CHK state and no XOR register.
  - DATA goes directly to DONE after word N.

## Test plan
- Single word: A5,01,93,00,50,00 -> one imem_we pulse, addr 0, data 0x00500093. Then core_rst=0 and done=1 one cycle after the last byte; word_count=1.
- Garbage then frame: 00,FF,A5,02 followed by 8 payload bytes -> leading bytes ignored; writes at addr 0 and 1; done=1.
- Bad length: A5,00 -> err=1, core_rst=1, in_ready=0, no imem_we. Same result for A5,41 with IMEM_WORDS=64.
- Checksum (macro on): A5,01,93,00,50,00,C3 -> done=1. With trailing byte C4 instead -> err=1, core_rst stays 1.
- Restart mid-frame: A5,02, then 5 payload bytes, then restart pulse -> state IDLE, word_count=0, core_rst=1. A fresh single-word frame then completes normally.
- Reset asserted while in_valid=1 with data A5 -> in_ready=0 and the byte is not accepted. After reset deasserts, all outputs hold their reset values until a header arrives.

Source files
------------

// File: rtl/imem_loader_if.sv
// -----------------------------------------------------------------------------
// imem_loader_if
// Byte-stream valid/ready channel feeding the boot loader.
//   in_valid  : source has a byte on in_data
//   in_data   : 8-bit payload byte
//   in_ready  : loader can take a byte; transfer on in_valid && in_ready
// Modports: master = byte source, slave = loader.
// -----------------------------------------------------------------------------
interface imem_loader_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
// Boot-time program loader for the RV32I core. Parses a framed byte stream
// (0xA5, N, 4N little-endian payload bytes [, checksum]) and writes each
// assembled 32-bit word into instruction memory. The core stays in reset until
// the whole frame has been committed.
//
// Optional feature: define LOADER_CHECKSUM_EN to expect a trailing XOR checksum
// byte over all payload bytes; a mismatch rejects the frame.
//
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   i_restart       one-cycle abort/reload request, returns to IDLE
//   s_in            byte-stream channel (imem_loader_if.slave)
//   o_imem_we       one-cycle write pulse per assembled word
//   o_imem_addr     word address of the write
//   o_imem_wdata    word to write
//   o_core_rst      core reset, high until the frame is committed
//   o_done          frame committed, core running
//   o_err           frame rejected, core held in reset
//   o_word_count    words written in the current frame
// -----------------------------------------------------------------------------
module imem_loader #(
    parameter int IMEM_WORDS = 64,
    parameter int ADDR_W     = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_restart,
    imem_loader_if.slave      s_in,
    output logic              o_imem_we,
    output logic [ADDR_W-1:0] o_imem_addr,
    output logic [31:0]       o_imem_wdata,
    output logic              o_core_rst,
    output logic              o_done,
    output logic              o_err,
    output logic [ADDR_W:0]   o_word_count
);

    localparam logic [7:0] HDR_BYTE = 8'hA5;
    localparam logic [8:0] MAX_LEN  = 9'(IMEM_WORDS);

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        ST_IDLE, ST_LEN, ST_DATA, ST_CHK, ST_DONE, ST_ERR
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE, ST_LEN, ST_DATA, ST_DONE, ST_ERR
    } state_t;
`endif

    state_t            r_state;
    state_t            w_state_nx;
    logic [ADDR_W:0]   r_len;
    logic [ADDR_W:0]   r_word_count;
    logic [1:0]        r_byte_cnt;
    logic [23:0]       r_word;
    logic              r_imem_we;
    logic [ADDR_W-1:0] r_imem_addr;
    logic [31:0]       r_imem_wdata;
    logic              r_core_rst;
    logic              r_done;
    logic              r_err;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        r_xor;
`endif

    logic              w_ready;
    logic              w_acc;
    logic              w_len_bad;
    logic [ADDR_W:0]   w_wc_inc;
    logic              w_last_word;

    // Ready is a pure function of state so a byte can be taken every cycle;
    // reset forces it low so nothing is accepted while the block is reset.
    assign w_ready     = !reset && (r_state != ST_DONE) && (r_state != ST_ERR);
    assign w_acc       = s_in.in_valid && w_ready;
    assign w_len_bad   = (s_in.in_data == 8'd0) || ({1'b0, s_in.in_data} > MAX_LEN);
    assign w_wc_inc    = r_word_count + (ADDR_W+1)'(1);
    assign w_last_word = (w_wc_inc == r_len);

    assign s_in.in_ready = w_ready;
    assign o_imem_we     = r_imem_we;
    assign o_imem_addr   = r_imem_addr;
    assign o_imem_wdata  = r_imem_wdata;
    assign o_core_rst    = r_core_rst;
    assign o_done        = r_done;
    assign o_err         = r_err;
    assign o_word_count  = r_word_count;

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        if (w_acc) begin
            case (r_state)
                ST_IDLE: if (s_in.in_data == HDR_BYTE) w_state_nx = ST_LEN;
                ST_LEN:  w_state_nx = w_len_bad ? ST_ERR : ST_DATA;
                ST_DATA: begin
                    if (r_byte_cnt == 2'd3 && w_last_word) begin
`ifdef LOADER_CHECKSUM_EN
                        w_state_nx = ST_CHK;
`else
                        w_state_nx = ST_DONE;
`endif
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                ST_CHK:  w_state_nx = (s_in.in_data == r_xor) ? ST_DONE : ST_ERR;
`endif
                default: ;
            endcase
        end
        // restart wins over a byte accepted in the same cycle
        if (i_restart) w_state_nx = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_len        <= '0;
            r_word_count <= '0;
            r_byte_cnt   <= '0;
            r_word       <= '0;
            r_imem_we    <= 1'b0;
            r_imem_addr  <= '0;
            r_imem_wdata <= '0;
            r_core_rst   <= 1'b1;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            r_xor        <= '0;
`endif
        end else if (i_restart) begin
            // imem address/data are left as-is; words already written stay.
            r_word_count <= '0;
            r_byte_cnt   <= '0;
            r_imem_we    <= 1'b0;
            r_core_rst   <= 1'b1;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            r_xor        <= '0;
`endif
        end else begin
            // Status follows the state one edge later, so the core is only
            // released after the final imem write has committed.
            r_imem_we  <= 1'b0;
            r_core_rst <= (r_state != ST_DONE);
            r_done     <= (r_state == ST_DONE);
            r_err      <= (r_state == ST_ERR);
            if (w_acc) begin
                if (r_state == ST_LEN) begin
                    r_len <= (ADDR_W+1)'(s_in.in_data);
                end
                if (r_state == ST_DATA) begin
                    r_byte_cnt <= r_byte_cnt + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                    r_xor      <= r_xor ^ s_in.in_data;
`endif
                    if (r_byte_cnt == 2'd3) begin
                        r_imem_we    <= 1'b1;
                        r_imem_addr  <= r_word_count[ADDR_W-1:0];
                        r_imem_wdata <= {s_in.in_data, r_word};
                        r_word_count <= w_wc_inc;
                    end else begin
                        // little-endian: earliest byte ends up in bits [7:0]
                        r_word <= {s_in.in_data, r_word[23:8]};
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        restart = 1'b0;
    logic        o_we;
    logic [5:0]  o_addr;
    logic [31:0] o_wdata;
    logic        o_core_rst;
    logic        o_done;
    logic        o_err;
    logic [6:0]  o_wc;

    int n_pass  = 0;
    int n_total = 0;

    logic [37:0] wlog[$];

    imem_loader_if u_if ();

    imem_loader #(.IMEM_WORDS(64), .ADDR_W(6)) dut (
        .clk          (clk),
        .reset        (reset),
        .i_restart    (restart),
        .s_in         (u_if),
        .o_imem_we    (o_we),
        .o_imem_addr  (o_addr),
        .o_imem_wdata (o_wdata),
        .o_core_rst   (o_core_rst),
        .o_done       (o_done),
        .o_err        (o_err),
        .o_word_count (o_wc)
    );

    always #5 clk = ~clk;

    // capture every write pulse mid-cycle
    always @(negedge clk) begin
        if (o_we === 1'b1) wlog.push_back({o_addr, o_wdata});
    end

    typedef struct {
        logic        vld;
        logic [7:0]  dat;
        logic        we;
        logic [5:0]  addr;
        logic [31:0] wdata;
        logic        crst;
        logic        done;
        logic        err;
        logic        rdy;
        logic [6:0]  wc;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        u_if.in_valid = 1'b1;
        u_if.in_data  = b;
        step();
        u_if.in_valid = 1'b0;
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        step();
        restart = 1'b0;
    endtask

    task automatic frame1();
        send(8'hA5); send(8'h01);
        send(8'h93); send(8'h00); send(8'h50); send(8'h00);
`ifdef LOADER_CHECKSUM_EN
        send(8'hC3);
`endif
    endtask

    // status bundle {core_rst, done, err, ready, word_count}
    function automatic logic [63:0] st();
        return 64'({o_core_rst, o_done, o_err, u_if.in_ready, o_wc});
    endfunction

    function automatic logic [63:0] st_exp(input logic c, input logic d, input logic e,
                                           input logic r, input logic [6:0] w);
        return 64'({c, d, e, r, w});
    endfunction

    initial begin
        logic [37:0] w0;
        u_if.in_valid = 1'b0;
        u_if.in_data  = 8'h00;

        // reset state
        repeat (3) step();
        chk("reset_ready", 64'(u_if.in_ready), 64'(0));
        chk("reset_outs", 64'({o_we, o_addr, o_wdata, o_core_rst, o_done, o_err, o_wc}),
            64'({1'b0, 6'd0, 32'd0, 1'b1, 1'b0, 1'b0, 7'd0}));
        reset = 1'b0;
        step();
        chk("idle_status", st(), st_exp(1, 0, 0, 1, 0));

        // single-word frame, cycle by cycle
        vq.push_back('{1'b1, 8'hA5, 1'b0, 6'd0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 7'd0});
        vq.push_back('{1'b1, 8'h01, 1'b0, 6'd0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 7'd0});
        vq.push_back('{1'b1, 8'h93, 1'b0, 6'd0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 7'd0});
        vq.push_back('{1'b1, 8'h00, 1'b0, 6'd0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 7'd0});
        vq.push_back('{1'b1, 8'h50, 1'b0, 6'd0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 7'd0});
`ifdef LOADER_CHECKSUM_EN
        vq.push_back('{1'b1, 8'h00, 1'b1, 6'd0, 32'h00500093, 1'b1, 1'b0, 1'b0, 1'b1, 7'd1});
        vq.push_back('{1'b1, 8'hC3, 1'b0, 6'd0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 7'd1});
`else
        vq.push_back('{1'b1, 8'h00, 1'b1, 6'd0, 32'h00500093, 1'b1, 1'b0, 1'b0, 1'b0, 7'd1});
`endif
        vq.push_back('{1'b0, 8'h00, 1'b0, 6'd0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 7'd1});
        vq.push_back('{1'b0, 8'h00, 1'b0, 6'd0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 7'd1});

        for (int i = 0; i < vq.size(); i++) begin
            logic [63:0] act, exp;
            u_if.in_valid = vq[i].vld;
            u_if.in_data  = vq[i].dat;
            step();
            u_if.in_valid = 1'b0;
            act = 64'({o_we, o_we ? o_addr : 6'd0, o_we ? o_wdata : 32'd0,
                       o_core_rst, o_done, o_err, u_if.in_ready, o_wc});
            exp = 64'({vq[i].we, vq[i].addr, vq[i].wdata,
                       vq[i].crst, vq[i].done, vq[i].err, vq[i].rdy, vq[i].wc});
            chk($sformatf("vec%0d", i), act, exp);
        end

        // garbage then two-word frame
        pulse_restart();
        chk("restart_status", st(), st_exp(1, 0, 0, 1, 0));
        wlog.delete();
        send(8'h00); send(8'hFF);
        chk("garbage_ignored", st(), st_exp(1, 0, 0, 1, 0));
        send(8'hA5); send(8'h02);
        send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        send(8'h55); send(8'h66); send(8'h77); send(8'h88);
`ifdef LOADER_CHECKSUM_EN
        send(8'h88);
`endif
        step();
        chk("two_word_status", st(), st_exp(0, 1, 0, 0, 2));
        chk("two_word_nwrites", 64'(wlog.size()), 64'(2));
        if (wlog.size() == 2) begin
            chk("two_word_w0", 64'(wlog[0]), 64'({6'd0, 32'h44332211}));
            chk("two_word_w1", 64'(wlog[1]), 64'({6'd1, 32'h88776655}));
        end

        // bad length 0
        pulse_restart();
        wlog.delete();
        send(8'hA5); send(8'h00);
        step();
        chk("len0_status", st(), st_exp(1, 0, 1, 0, 0));
        // bad length 65
        pulse_restart();
        send(8'hA5); send(8'h41);
        step();
        chk("len65_status", st(), st_exp(1, 0, 1, 0, 0));
        chk("badlen_nwrites", 64'(wlog.size()), 64'(0));
        // length 64 is the largest legal frame
        pulse_restart();
        send(8'hA5); send(8'h40);
        step();
        chk("len64_accepted", st(), st_exp(1, 0, 0, 1, 0));

        // restart mid-frame, then a fresh frame
        pulse_restart();
        wlog.delete();
        send(8'hA5); send(8'h02);
        send(8'h11); send(8'h22); send(8'h33); send(8'h44); send(8'h55);
        chk("midframe_wc", st(), st_exp(1, 0, 0, 1, 1));
        pulse_restart();
        chk("midframe_restart", st(), st_exp(1, 0, 0, 1, 0));
        frame1();
        step();
        chk("after_restart_frame", st(), st_exp(0, 1, 0, 0, 1));
        chk("after_restart_nwrites", 64'(wlog.size()), 64'(2));
        if (wlog.size() == 2) begin
            w0 = wlog[1];
            chk("after_restart_w", 64'(w0), 64'({6'd0, 32'h00500093}));
        end

        // restart has priority over a header accepted in the same cycle
        pulse_restart();
        wlog.delete();
        u_if.in_valid = 1'b1;
        u_if.in_data  = 8'hA5;
        pulse_restart();
        u_if.in_valid = 1'b0;
        send(8'h01); send(8'h93); send(8'h00); send(8'h50); send(8'h00);
        step();
        chk("restart_prio_status", st(), st_exp(1, 0, 0, 1, 0));
        chk("restart_prio_nwrites", 64'(wlog.size()), 64'(0));

`ifdef LOADER_CHECKSUM_EN
        // checksum mismatch
        pulse_restart();
        wlog.delete();
        send(8'hA5); send(8'h01);
        send(8'h93); send(8'h00); send(8'h50); send(8'h00);
        send(8'hC4);
        step();
        chk("cksum_bad_status", st(), st_exp(1, 0, 1, 0, 1));
        chk("cksum_bad_nwrites", 64'(wlog.size()), 64'(1));
`endif

        // reset with a header on the bus, from the DONE state
        pulse_restart();
        frame1();
        step();
        chk("pre_reset_done", st(), st_exp(0, 1, 0, 0, 1));
        reset = 1'b1;
        u_if.in_valid = 1'b1;
        u_if.in_data  = 8'hA5;
        #1;
        chk("reset_ready_low", 64'(u_if.in_ready), 64'(0));
        step();
        chk("reset_clears", 64'({o_we, o_addr, o_wdata, o_core_rst, o_done, o_err, o_wc}),
            64'({1'b0, 6'd0, 32'd0, 1'b1, 1'b0, 1'b0, 7'd0}));
        reset = 1'b0;
        u_if.in_valid = 1'b0;
        wlog.delete();
        step();
        step();
        chk("post_reset_hold", 64'({o_we, o_addr, o_wdata, o_core_rst, o_done, o_err, o_wc}),
            64'({1'b0, 6'd0, 32'd0, 1'b1, 1'b0, 1'b0, 7'd0}));
        send(8'h01); send(8'h93); send(8'h00); send(8'h50); send(8'h00);
        step();
        chk("post_reset_no_hdr", st(), st_exp(1, 0, 0, 1, 0));
        chk("post_reset_nwrites", 64'(wlog.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
